// File: rtl/vx_fetch_pkg.sv
// Shared fetch-path types: the buffered instruction record and warp-id width helper,
// reused by the icache response path, the fetch buffer and decode.
package vx_fetch_pkg;

  localparam int VX_NUM_WARPS   = 4;
  localparam int VX_NUM_THREADS = 4;

  typedef struct packed {
    logic [VX_NUM_THREADS-1:0] tmask;
    logic [31:0]               PC;
    logic [31:0]               instr;
  } fetch_entry_t;

  // Width of a warp id; a single-warp build still gets a 1-bit id.
  function automatic int nwBits(input int numWarps);
    return (numWarps > 1) ? $clog2(numWarps) : 1;
  endfunction

endpackage

// File: rtl/vx_fetch_fifo.sv
// Single-warp instruction FIFO with a flush that empties it in one cycle,
// including anything pushed on the same edge.
module vx_fetch_fifo
  import vx_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic         empty,
  output logic         full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Flush skips the read pointer past every written slot, so a same-cycle push is dropped.
  always_comb begin
    wrPtr_d = wrPtr_q + PTR_W'(push);
    rdPtr_d = rdPtr_q + PTR_W'(pop);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    if (flush) begin
      count_d = '0;
      rdPtr_d = wrPtr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wrPtr_q] <= din;
    end
  end

  assign dout  = mem_q[rdPtr_q];
  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/vx_fetch_buffer.sv
// Per-warp fetch buffer: one FIFO per warp, round-robin selection toward decode,
// per-warp flush on redirect so a stalled warp never blocks the others.
module vx_fetch_buffer
  import vx_fetch_pkg::*;
#(
  parameter int NUM_WARPS   = VX_NUM_WARPS,
  parameter int NUM_THREADS = VX_NUM_THREADS,
  parameter int DEPTH       = 2,
  localparam int NW_BITS    = nwBits(NUM_WARPS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NW_BITS-1:0]     in_wid,
  input  logic [NUM_THREADS-1:0] in_tmask,
  input  logic [31:0]            in_PC,
  input  logic [31:0]            in_instr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NW_BITS-1:0]     out_wid,
  output logic [NUM_THREADS-1:0] out_tmask,
  output logic [31:0]            out_PC,
  output logic [31:0]            out_instr,
  input  logic                   flush_valid,
  input  logic [NW_BITS-1:0]     flush_wid,
  output logic [NUM_WARPS-1:0]   pending_mask
);

  fetch_entry_t       inEntry;
  fetch_entry_t       headEntry [NUM_WARPS];
  logic [NUM_WARPS-1:0] emptyVec, fullVec, pushVec, popVec, flushVec, candVec;
  logic [NW_BITS-1:0] lastGrant_q, lastGrant_d;
  logic [NW_BITS-1:0] grant, scanIdx;
  logic               anyCand, outFire;

  assign inEntry  = '{tmask: in_tmask, PC: in_PC, instr: in_instr};
  assign in_ready = !fullVec[in_wid];
  assign outFire  = anyCand && out_ready;

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
    assign pushVec[w]  = in_valid && in_ready && (in_wid == NW_BITS'(w));
    assign flushVec[w] = flush_valid && (flush_wid == NW_BITS'(w));
    assign candVec[w]  = !emptyVec[w] && !flushVec[w];
    assign popVec[w]   = outFire && (grant == NW_BITS'(w));

    vx_fetch_fifo #(
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (pushVec[w]),
      .pop   (popVec[w]),
      .flush (flushVec[w]),
      .din   (inEntry),
      .dout  (headEntry[w]),
      .empty (emptyVec[w]),
      .full  (fullVec[w])
    );
  end

  // Scan from farthest to nearest so the last hit is the first candidate after lastGrant.
  always_comb begin
    grant   = lastGrant_q;
    scanIdx = lastGrant_q;
    anyCand = 1'b0;
    for (int i = NUM_WARPS; i >= 1; i--) begin
      scanIdx = lastGrant_q + NW_BITS'(i);
      if (candVec[scanIdx]) begin
        grant   = scanIdx;
        anyCand = 1'b1;
      end
    end
  end

  assign lastGrant_d = outFire ? grant : lastGrant_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      lastGrant_q <= NW_BITS'(NUM_WARPS - 1);
    end else begin
      lastGrant_q <= lastGrant_d;
    end
  end

  assign out_valid    = anyCand;
  assign out_wid      = grant;
  assign out_tmask    = headEntry[grant].tmask;
  assign out_PC       = headEntry[grant].PC;
  assign out_instr    = headEntry[grant].instr;
  assign pending_mask = ~emptyVec;

endmodule

// File: tb/tb_vx_fetch_buffer.sv
// Directed, table-driven bench for vx_fetch_buffer with hand-written reset sequences.
module tb_vx_fetch_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_wid;
  logic [3:0]  in_tmask;
  logic [31:0] in_PC;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_wid;
  logic [3:0]  out_tmask;
  logic [31:0] out_PC;
  logic [31:0] out_instr;
  logic        flush_valid;
  logic [1:0]  flush_wid;
  logic [3:0]  pending_mask;

  int passCount  = 0;
  int checkCount = 0;

  always #5 clk = ~clk;

  vx_fetch_buffer #(
    .NUM_WARPS   (4),
    .NUM_THREADS (4),
    .DEPTH       (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_wid       (in_wid),
    .in_tmask     (in_tmask),
    .in_PC        (in_PC),
    .in_instr     (in_instr),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_wid      (out_wid),
    .out_tmask    (out_tmask),
    .out_PC       (out_PC),
    .out_instr    (out_instr),
    .flush_valid  (flush_valid),
    .flush_wid    (flush_wid),
    .pending_mask (pending_mask)
  );

  typedef struct {
    logic        inValid;
    logic [1:0]  inWid;
    logic [31:0] inPC;
    logic        outReady;
    logic        flushValid;
    logic [1:0]  flushWid;
    logic        expInReady;
    logic        expOutValid;
    logic [1:0]  expWid;
    logic [31:0] expPC;
    logic [3:0]  expPending;
  } vec_t;

  vec_t vecs[$];

  // Side data is derived from the PC so one expected PC pins down the whole entry.
  function automatic logic [3:0] tmaskOf(input logic [31:0] pc);
    return pc[5:2];
  endfunction

  function automatic logic [31:0] instrOf(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  function automatic void addVec(input logic iv, input logic [1:0] iw, input logic [31:0] pc,
                                 input logic ordy, input logic fv, input logic [1:0] fw,
                                 input logic eRdy, input logic eVal, input logic [1:0] eWid,
                                 input logic [31:0] ePC, input logic [3:0] ePend);
    vec_t v;
    v.inValid = iv;  v.inWid = iw;  v.inPC = pc;  v.outReady = ordy;
    v.flushValid = fv;  v.flushWid = fw;
    v.expInReady = eRdy;  v.expOutValid = eVal;  v.expWid = eWid;
    v.expPC = ePC;  v.expPending = ePend;
    vecs.push_back(v);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic iv, input logic [1:0] iw, input logic [31:0] pc,
                               input logic ordy, input logic fv, input logic [1:0] fw);
    in_valid    = iv;
    in_wid      = iw;
    in_PC       = pc;
    in_tmask    = tmaskOf(pc);
    in_instr    = instrOf(pc);
    out_ready   = ordy;
    flush_valid = fv;
    flush_wid   = fw;
    #1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkHead(input string tag, input logic [1:0] wid, input logic [31:0] pc);
    checkOutput({tag, " out_valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, " out_wid"},   32'(out_wid),   32'(wid));
    checkOutput({tag, " out_PC"},    out_PC,         pc);
    checkOutput({tag, " out_tmask"}, 32'(out_tmask), 32'(tmaskOf(pc)));
    checkOutput({tag, " out_instr"}, out_instr,      instrOf(pc));
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, " out_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, " pending_mask"}, 32'(pending_mask), 32'd0);
    for (int w = 0; w < 4; w++) begin
      in_wid = 2'(w);
      #1;
      checkOutput($sformatf("%s in_ready wid%0d", tag, w), 32'(in_ready), 32'd1);
    end
  endtask

  initial begin
    reset = 1'b0;
    applyStimulus(1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 2'd0);
    nextCycle();
    nextCycle();
    reset = 1'b1;
    #1;
    checkIdle("reset");

    // Round-robin: starts at warp 0, refill of warp 0 is served after warp 3.
    addVec(1, 0, 32'h200, 0, 0, 0,  1, 0, 0, 32'h0,   4'b0000);
    addVec(1, 1, 32'h300, 0, 0, 0,  1, 1, 0, 32'h200, 4'b0001);
    addVec(1, 3, 32'h400, 0, 0, 0,  1, 1, 0, 32'h200, 4'b0011);
    addVec(0, 0, 32'h0,   1, 0, 0,  1, 1, 0, 32'h200, 4'b1011);
    addVec(1, 0, 32'h204, 1, 0, 0,  1, 1, 1, 32'h300, 4'b1010);
    addVec(0, 0, 32'h0,   1, 0, 0,  1, 1, 3, 32'h400, 4'b1001);
    addVec(0, 0, 32'h0,   1, 0, 0,  1, 1, 0, 32'h204, 4'b0001);
    addVec(0, 0, 32'h0,   1, 0, 0,  1, 0, 0, 32'h0,   4'b0000);
    // Single warp fill then drain in order.
    addVec(1, 2, 32'h100, 0, 0, 0,  1, 0, 0, 32'h0,   4'b0000);
    addVec(1, 2, 32'h104, 0, 0, 0,  1, 1, 2, 32'h100, 4'b0100);
    addVec(0, 2, 32'h0,   0, 0, 0,  0, 1, 2, 32'h100, 4'b0100);
    addVec(0, 2, 32'h0,   1, 0, 0,  0, 1, 2, 32'h100, 4'b0100);
    addVec(0, 2, 32'h0,   1, 0, 0,  1, 1, 2, 32'h104, 4'b0100);
    addVec(0, 2, 32'h0,   1, 0, 0,  1, 0, 0, 32'h0,   4'b0000);
    // Same-cycle push/pop on warp 1, then full warp refuses a push despite a pop.
    addVec(1, 1, 32'h500, 0, 0, 0,  1, 0, 0, 32'h0,   4'b0000);
    addVec(1, 1, 32'h504, 1, 0, 0,  1, 1, 1, 32'h500, 4'b0010);
    addVec(1, 1, 32'h508, 0, 0, 0,  1, 1, 1, 32'h504, 4'b0010);
    addVec(1, 1, 32'h50C, 1, 0, 0,  0, 1, 1, 32'h504, 4'b0010);
    addVec(0, 1, 32'h0,   1, 0, 0,  1, 1, 1, 32'h508, 4'b0010);
    addVec(0, 1, 32'h0,   1, 0, 0,  1, 0, 0, 32'h0,   4'b0000);
    // Flush of a full warp 3, then a flush that swallows an accepted push.
    addVec(1, 3, 32'h600, 0, 0, 0,  1, 0, 0, 32'h0,   4'b0000);
    addVec(1, 3, 32'h604, 0, 0, 0,  1, 1, 3, 32'h600, 4'b1000);
    addVec(1, 3, 32'h608, 1, 1, 3,  0, 0, 0, 32'h0,   4'b1000);
    addVec(0, 3, 32'h0,   1, 0, 0,  1, 0, 0, 32'h0,   4'b0000);
    addVec(1, 3, 32'h700, 0, 0, 0,  1, 0, 0, 32'h0,   4'b0000);
    addVec(1, 0, 32'h800, 0, 0, 0,  1, 1, 3, 32'h700, 4'b1000);
    addVec(1, 3, 32'h704, 1, 1, 3,  1, 1, 0, 32'h800, 4'b1001);
    addVec(0, 3, 32'h0,   1, 0, 0,  1, 0, 0, 32'h0,   4'b0000);

    for (int i = 0; i < vecs.size(); i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      applyStimulus(vecs[i].inValid, vecs[i].inWid, vecs[i].inPC,
                    vecs[i].outReady, vecs[i].flushValid, vecs[i].flushWid);
      checkOutput({tag, " in_ready"}, 32'(in_ready), 32'(vecs[i].expInReady));
      checkOutput({tag, " out_valid"}, 32'(out_valid), 32'(vecs[i].expOutValid));
      checkOutput({tag, " pending_mask"}, 32'(pending_mask), 32'(vecs[i].expPending));
      if (vecs[i].expOutValid) checkHead(tag, vecs[i].expWid, vecs[i].expPC);
      nextCycle();
    end

    // Mid-operation reset with three warps holding entries.
    applyStimulus(1'b1, 2'd0, 32'h900, 1'b0, 1'b0, 2'd0);
    nextCycle();
    applyStimulus(1'b1, 2'd1, 32'hA00, 1'b0, 1'b0, 2'd0);
    nextCycle();
    applyStimulus(1'b1, 2'd1, 32'hA04, 1'b0, 1'b0, 2'd0);
    nextCycle();
    applyStimulus(1'b1, 2'd2, 32'hB00, 1'b0, 1'b0, 2'd0);
    nextCycle();
    applyStimulus(1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 2'd0);
    checkOutput("prereset pending_mask", 32'(pending_mask), 32'b0111);
    checkHead("prereset", 2'd1, 32'hA00);

    reset = 1'b0;
    applyStimulus(1'b0, 2'd0, 32'h0, 1'b1, 1'b0, 2'd0);
    nextCycle();
    reset = 1'b1;
    #1;
    checkIdle("midreset");
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, 2'd0, 32'h0, 1'b1, 1'b0, 2'd0);
      checkOutput($sformatf("postreset drain%0d out_valid", c), 32'(out_valid), 32'd0);
      nextCycle();
    end

    // Warp 0 must regain first priority after reset.
    applyStimulus(1'b1, 2'd2, 32'hD00, 1'b0, 1'b0, 2'd0);
    nextCycle();
    applyStimulus(1'b1, 2'd0, 32'hC00, 1'b0, 1'b0, 2'd0);
    checkHead("postreset first", 2'd2, 32'hD00);
    nextCycle();
    applyStimulus(1'b0, 2'd0, 32'h0, 1'b1, 1'b0, 2'd0);
    checkHead("postreset prio0", 2'd0, 32'hC00);
    nextCycle();
    applyStimulus(1'b0, 2'd0, 32'h0, 1'b1, 1'b0, 2'd0);
    checkHead("postreset prio2", 2'd2, 32'hD00);
    nextCycle();
    applyStimulus(1'b0, 2'd0, 32'h0, 1'b1, 1'b0, 2'd0);
    checkOutput("postreset end out_valid", 32'(out_valid), 32'd0);
    checkOutput("postreset end pending_mask", 32'(pending_mask), 32'd0);
    nextCycle();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
